// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared definitions for the UART byte receiver. Holds the FSM
//               state encoding, the parity-mode selectors and the number of
//               bit slots per character (start, 8 data, parity, stop).
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Bit slots in one UART character: start + 8 data + parity + stop.
    localparam int FRAME_BITS = 11;

    // Parity-mode selectors for the PARITY_CHECK parameter.
    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    // Receiver FSM state encoding.
    typedef logic [2:0] state_t;
    localparam state_t S_IDLE   = 3'd0;
    localparam state_t S_START  = 3'd1;
    localparam state_t S_DATA   = 3'd2;
    localparam state_t S_PARITY = 3'd3;
    localparam state_t S_STOP   = 3'd4;
    localparam state_t S_BREAK  = 3'd5;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/rx_sync2.sv
`default_nettype none
// ============================================================================
// Module      : rx_sync2
// Description : Two-flop synchronizer for an idle-high asynchronous line.
//               Both flops reset to 1 so the receiver sees an idle line while
//               and right after reset.
// Ports       : clk   - sampling clock
//               reset - asynchronous reset, active low
//               d     - asynchronous input
//               q     - synchronized output
// Revision    : 1.0 - initial release
// ============================================================================
module rx_sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule : rx_sync2
`default_nettype wire

// File: rtl/uart_rx_byte.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_byte
// Description : Oversampling UART deframer feeding the RS decoder. Receives
//               start, 8 data bits (LSB first), a parity slot and a stop bit,
//               and hands each good byte over with a one-cycle CE strobe. A
//               block counter marks byte 0 of every BLOCK_LEN-byte codeword.
// Ports       : clk        - system clock
//               reset      - asynchronous reset, active low
//               Rx_D       - serial line, idle high, asynchronous
//               input_byte - last accepted byte, held until the next one
//               CE         - one-cycle strobe, input_byte valid
//               sob        - start of codeword, qualified by CE
//               frame_err  - one-cycle pulse, stop bit sampled low
//               parity_err - one-cycle pulse, parity slot mismatch
//               busy       - receiver is not idle
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 864,
    parameter int PARITY_CHECK = 0,
    parameter int BLOCK_LEN    = 204
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       Rx_D,
    output logic [7:0] input_byte,
    output logic       CE,
    output logic       sob,
    output logic       frame_err,
    output logic       parity_err,
    output logic       busy
);

    localparam int c_CNT_W     = $clog2(CLKS_PER_BIT);
    localparam int c_BLK_W     = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1;
    localparam int c_DATA_BITS = FRAME_BITS - 3;

    // First reload lands the start sample mid-bit; later reloads step a bit.
    localparam logic [c_CNT_W-1:0] c_HALF_LOAD = c_CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_CNT_W-1:0] c_FULL_LOAD = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]         c_LAST_IDX  = 3'(c_DATA_BITS - 1);
    localparam logic [c_BLK_W-1:0] c_BLK_LAST  = c_BLK_W'(BLOCK_LEN - 1);

    logic               w_rxs;
    logic               w_expired;
    logic               w_par_exp;
    logic               w_par_bad;

    state_t             r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [2:0]         r_idx;
    logic [7:0]         r_shift;
    logic               r_par_bad;
    logic [c_BLK_W-1:0] r_blk;
    logic [7:0]         r_byte;
    logic               r_ce;
    logic               r_sob;
    logic               r_fe;
    logic               r_pe;

    rx_sync2 u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (Rx_D),
        .q     (w_rxs)
    );

    assign w_expired = (r_cnt == '0);

    // Expected parity slot value from the assembled data bits.
    assign w_par_exp = (PARITY_CHECK == PAR_ODD) ? ~(^r_shift) : (^r_shift);
    assign w_par_bad = (PARITY_CHECK != PAR_NONE) && (w_rxs != w_par_exp);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_shift   <= '0;
            r_par_bad <= 1'b0;
            r_blk     <= '0;
            r_byte    <= '0;
            r_ce      <= 1'b0;
            r_sob     <= 1'b0;
            r_fe      <= 1'b0;
            r_pe      <= 1'b0;
        end else begin
            // Strobes are single-cycle by default.
            r_ce  <= 1'b0;
            r_sob <= 1'b0;
            r_fe  <= 1'b0;
            r_pe  <= 1'b0;

            if (r_state != S_IDLE && r_state != S_BREAK && !w_expired) begin
                r_cnt <= r_cnt - c_CNT_W'(1);
            end

            case (r_state)
                S_IDLE: begin
                    if (!w_rxs) begin
                        r_cnt   <= c_HALF_LOAD;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (w_expired) begin
                        if (w_rxs) begin
                            // Line is high again mid start bit: a glitch.
                            r_state <= S_IDLE;
                        end else begin
                            r_cnt   <= c_FULL_LOAD;
                            r_idx   <= '0;
                            r_state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (w_expired) begin
                        r_shift[r_idx] <= w_rxs;
                        r_cnt          <= c_FULL_LOAD;
                        if (r_idx == c_LAST_IDX) begin
                            r_state <= S_PARITY;
                        end else begin
                            r_idx <= r_idx + 3'd1;
                        end
                    end
                end
                S_PARITY: begin
                    if (w_expired) begin
                        r_par_bad <= w_par_bad;
                        r_cnt     <= c_FULL_LOAD;
                        r_state   <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (w_expired) begin
                        if (!w_rxs) begin
                            // Line may be held low (break); wait it out.
                            r_fe    <= 1'b1;
                            r_state <= S_BREAK;
                        end else if (r_par_bad) begin
                            r_pe    <= 1'b1;
                            r_state <= S_IDLE;
                        end else begin
                            r_ce    <= 1'b1;
                            r_byte  <= r_shift;
                            r_sob   <= (r_blk == '0);
                            r_blk   <= (r_blk == c_BLK_LAST) ? '0 : r_blk + c_BLK_W'(1);
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_BREAK: begin
                    if (w_rxs) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign input_byte = r_byte;
    assign CE         = r_ce;
    assign sob        = r_sob;
    assign frame_err  = r_fe;
    assign parity_err = r_pe;
    assign busy       = (r_state != S_IDLE);

endmodule : uart_rx_byte
`default_nettype wire

// File: tb/tb_uart_rx_byte.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_byte
// Description : Self-checking bench for uart_rx_byte. Four receivers share the
//               clock: no parity, even parity, odd parity (all 16 clocks per
//               bit) and a fast no-parity one (8 clocks per bit) for a
//               two-codeword stream. Expected events come from a table or a
//               frame-level reference model and are matched against events
//               observed on the outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_byte;

    localparam int K_CE = 1;
    localparam int K_FE = 2;
    localparam int K_PE = 3;

    typedef struct {
        int         inst;
        int         kind;
        logic [7:0] data;
        logic       sob;
        int         cyc;
    } ev_t;

    typedef struct {
        int         inst;
        logic [7:0] data;
        logic       par;
        logic       stop;
        int         kind;
    } vec_t;

    logic       clk = 1'b0;
    int         cyc = 0;
    logic [3:0] rx;
    logic [3:0] rst_n;
    logic [7:0] ib [4];
    logic [3:0] ce;
    logic [3:0] sob;
    logic [3:0] fe;
    logic [3:0] pe;
    logic [3:0] busy;

    ev_t        act_q[$];
    ev_t        exp_q[$];
    int         acc_cnt [4];
    logic [7:0] prev_ib [4];
    int         n_err     = 0;
    int         n_checks  = 0;
    int         hold_viol = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_byte #(.CLKS_PER_BIT(16), .PARITY_CHECK(0), .BLOCK_LEN(204)) dut (
        .clk(clk), .reset(rst_n[0]), .Rx_D(rx[0]), .input_byte(ib[0]), .CE(ce[0]),
        .sob(sob[0]), .frame_err(fe[0]), .parity_err(pe[0]), .busy(busy[0]));
    uart_rx_byte #(.CLKS_PER_BIT(16), .PARITY_CHECK(1), .BLOCK_LEN(204)) dut_e (
        .clk(clk), .reset(rst_n[1]), .Rx_D(rx[1]), .input_byte(ib[1]), .CE(ce[1]),
        .sob(sob[1]), .frame_err(fe[1]), .parity_err(pe[1]), .busy(busy[1]));
    uart_rx_byte #(.CLKS_PER_BIT(16), .PARITY_CHECK(2), .BLOCK_LEN(204)) dut_o (
        .clk(clk), .reset(rst_n[2]), .Rx_D(rx[2]), .input_byte(ib[2]), .CE(ce[2]),
        .sob(sob[2]), .frame_err(fe[2]), .parity_err(pe[2]), .busy(busy[2]));
    uart_rx_byte #(.CLKS_PER_BIT(8), .PARITY_CHECK(0), .BLOCK_LEN(204)) dut_b (
        .clk(clk), .reset(rst_n[3]), .Rx_D(rx[3]), .input_byte(ib[3]), .CE(ce[3]),
        .sob(sob[3]), .frame_err(fe[3]), .parity_err(pe[3]), .busy(busy[3]));

    // Event recorder plus hold rules: input_byte moves only with CE, sob only with CE.
    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (ce[k]) act_q.push_back('{k, K_CE, ib[k], sob[k], cyc});
            if (fe[k]) act_q.push_back('{k, K_FE, ib[k], 1'b0, cyc});
            if (pe[k]) act_q.push_back('{k, K_PE, ib[k], 1'b0, cyc});
            if (rst_n[k] && ((ib[k] !== prev_ib[k] && !ce[k]) || (sob[k] && !ce[k])))
                hold_viol <= hold_viol + 1;
            prev_ib[k] <= ib[k];
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL timeout: simulation did not finish, errors=%0d", n_err);
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic int cpb_of(input int k);
        return (k == 3) ? 8 : 16;
    endfunction

    function automatic int mode_of(input int k);
        return (k == 3) ? 0 : k;
    endfunction

    // Frame-level reference: what the receiver must report for one character.
    function automatic int ref_kind(input int mode, input logic [7:0] d, input logic p, input logic s);
        int ones;
        ones = $countones(d);
        if (!s) return K_FE;
        if (mode == 1 && int'(p) != (ones % 2)) return K_PE;
        if (mode == 2 && int'(p) != ((ones + 1) % 2)) return K_PE;
        return K_CE;
    endfunction

    // Called and returns at 1 time unit after a rising edge.
    task automatic idle(input int n);
        if (n > 0) begin
            repeat (n) @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input int k, input logic [7:0] d, input logic p, input logic s,
                              input int kind);
        int         cpb;
        logic [10:0] f;
        ev_t        e;
        cpb    = cpb_of(k);
        f      = {s, p, d, 1'b0};
        e.inst = k;
        e.kind = kind;
        e.data = d;
        e.sob  = (acc_cnt[k] == 0);
        // Two synchronizer cycles, half a bit to the start sample, ten more bits, one register.
        e.cyc  = cyc + 2 + cpb / 2 + 10 * cpb + 1;
        if (kind == K_CE) acc_cnt[k] = (acc_cnt[k] + 1) % 204;
        exp_q.push_back(e);
        for (int i = 0; i < 11; i++) begin
            rx[k] = f[i];
            idle(cpb);
        end
    endtask

    task automatic drain(input int k);
        ev_t e;
        ev_t a;
        int  idx;
        int  left;
        bit  done;
        done = 1'b0;
        while (!done) begin
            idx = -1;
            for (int i = 0; i < exp_q.size(); i++)
                if (idx < 0 && exp_q[i].inst == k) idx = i;
            if (idx < 0) begin
                done = 1'b1;
            end else begin
                e = exp_q[idx];
                exp_q.delete(idx);
                idx = -1;
                for (int i = 0; i < act_q.size(); i++)
                    if (idx < 0 && act_q[i].inst == k) idx = i;
                if (idx < 0) begin
                    check($sformatf("inst%0d event_seen(kind %0d)", k, e.kind), 0, 1);
                end else begin
                    a = act_q[idx];
                    act_q.delete(idx);
                    check($sformatf("inst%0d kind", k), a.kind, e.kind);
                    check($sformatf("inst%0d cycle", k), a.cyc, e.cyc);
                    if (e.kind == K_CE) begin
                        check($sformatf("inst%0d byte", k), int'(a.data), int'(e.data));
                        check($sformatf("inst%0d sob", k), int'(a.sob), int'(e.sob));
                    end
                end
            end
        end
        left = 0;
        for (int i = 0; i < act_q.size(); i++)
            if (act_q[i].inst == k) left++;
        for (int i = act_q.size() - 1; i >= 0; i--)
            if (act_q[i].inst == k) act_q.delete(i);
        check($sformatf("inst%0d extra_events", k), left, 0);
    endtask

    initial begin
        vec_t       tbl [11];
        logic [7:0] d;
        logic       p;
        logic       s;
        int         gap;
        int         bc;

        rx    = '1;
        rst_n = '0;
        for (int k = 0; k < 4; k++) acc_cnt[k] = 0;

        tbl[0]  = '{0, 8'hA5, 1'b0, 1'b1, K_CE};
        tbl[1]  = '{1, 8'h07, 1'b0, 1'b1, K_PE};
        tbl[2]  = '{1, 8'h07, 1'b1, 1'b1, K_CE};
        tbl[3]  = '{1, 8'h00, 1'b0, 1'b1, K_CE};
        tbl[4]  = '{1, 8'h80, 1'b0, 1'b1, K_PE};
        tbl[5]  = '{2, 8'h07, 1'b0, 1'b1, K_CE};
        tbl[6]  = '{2, 8'h07, 1'b1, 1'b1, K_PE};
        tbl[7]  = '{2, 8'hFF, 1'b1, 1'b1, K_CE};
        tbl[8]  = '{0, 8'h5A, 1'b1, 1'b0, K_FE};
        tbl[9]  = '{0, 8'hC3, 1'b1, 1'b1, K_CE};
        tbl[10] = '{1, 8'h07, 1'b0, 1'b0, K_FE};

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("reset input_byte", int'(ib[0]), 0);
        check("reset CE", int'(ce[0]), 0);
        check("reset sob", int'(sob[0]), 0);
        check("reset frame_err", int'(fe[0]), 0);
        check("reset parity_err", int'(pe[0]), 0);
        check("reset busy", int'(busy), 0);
        rst_n = '1;
        idle(4);

        // Table vectors.
        for (int i = 0; i < 11; i++) begin
            send_frame(tbl[i].inst, tbl[i].data, tbl[i].par, tbl[i].stop, tbl[i].kind);
            rx[tbl[i].inst] = 1'b1;
            idle(2 * cpb_of(tbl[i].inst));
            drain(tbl[i].inst);
        end

        // Low glitch of 3 cycles: false start only.
        rx[0] = 1'b0;
        idle(3);
        rx[0] = 1'b1;
        bc = 0;
        repeat (30) begin
            @(negedge clk);
            if (busy[0]) bc++;
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (bc < 1 || bc > 8) begin
            n_err++;
            $display("FAIL glitch_busy: busy high %0d cycles, required 1..8", bc);
        end
        check("glitch busy back low", int'(busy[0]), 0);
        drain(0);

        // Stop bit low followed by a held-low line, then a clean byte.
        send_frame(0, 8'h3C, 1'b0, 1'b0, K_FE);
        idle(20);
        check("break busy", int'(busy[0]), 1);
        idle(20);
        rx[0] = 1'b1;
        idle(16);
        check("after break busy", int'(busy[0]), 0);
        drain(0);
        send_frame(0, 8'h11, 1'b0, 1'b1, K_CE);
        rx[0] = 1'b1;
        idle(32);
        drain(0);

        // Randomized frames against the reference model, back-to-back where allowed.
        for (int k = 0; k < 3; k++) begin
            for (int n = 0; n < 20; n++) begin
                d = 8'($urandom);
                p = 1'($urandom % 2);
                s = (($urandom % 8) != 0);
                send_frame(k, d, p, s, ref_kind(mode_of(k), d, p, s));
                rx[k] = 1'b1;
                gap = s ? int'($urandom % 4) : 1 + int'($urandom % 3);
                idle(gap);
            end
            idle(2 * cpb_of(k));
            drain(k);
        end

        // Two full codewords back-to-back.
        for (int i = 0; i < 408; i++) begin
            d = 8'($urandom);
            send_frame(3, d, 1'b0, 1'b1, K_CE);
        end
        rx[3] = 1'b1;
        idle(32);
        drain(3);

        // Reset in the middle of the data bits.
        rx[0] = 1'b0;
        idle(16);
        rx[0] = 1'b0;
        idle(16);
        rx[0] = 1'b1;
        idle(16);
        rx[0] = 1'b0;
        idle(8);
        check("mid-data busy", int'(busy[0]), 1);
        rst_n[0] = 1'b0;
        #1;
        check("mid reset busy", int'(busy[0]), 0);
        check("mid reset input_byte", int'(ib[0]), 0);
        rx[0] = 1'b1;
        idle(3);
        rst_n[0]   = 1'b1;
        acc_cnt[0] = 0;
        idle(32);
        drain(0);
        send_frame(0, 8'hFF, 1'b0, 1'b1, K_CE);
        rx[0] = 1'b1;
        idle(32);
        drain(0);

        check("input_byte/sob hold violations", hold_viol, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule : tb_uart_rx_byte
`default_nettype wire
